// File: rtl/seq_shift_unit.sv
// seq_shift_unit: multi-cycle 32-bit barrel shifter (sll / sra) using five fixed-latency stages
// Ports:
//   i_clock        - sole clock, rising edge
//   i_reset_n      - synchronous active-low reset
//   i_start        - request strobe, honoured only while o_ready=1
//   i_op_sra       - 0 = logical left shift, 1 = arithmetic right shift
//   i_shamt[4:0]   - shift amount 0-31
//   i_data_in[31:0]- operand
//   o_ready        - a request can be accepted this cycle
//   o_busy         - a shift is in progress
//   o_result[31:0] - last completed result, held between completions
//   o_result_valid - one-cycle pulse marking a new result
module seq_shift_unit (
   input  logic        i_clock,
   input  logic        i_reset_n,
   input  logic        i_start,
   input  logic        i_op_sra,
   input  logic [4:0]  i_shamt,
   input  logic [31:0] i_data_in,
   output logic        o_ready,
   output logic        o_busy,
   output logic [31:0] o_result,
   output logic        o_result_valid
);
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   state_t      r_state;
   logic [2:0]  r_k;
   logic [31:0] r_work;
   logic [31:0] r_result;
   logic [4:0]  r_shamt;
   logic        r_op;
   logic        r_ready;
   logic        r_busy;
   logic        r_valid;
   logic        w_accept;
   logic [4:0]  w_amt;
   logic        w_en;
   logic [31:0] w_shifted;
   logic [31:0] w_next;
   assign w_accept  = i_start & r_ready;
   // stage k applies weight 16>>k, gated by shamt bit (4-k)
   assign w_amt     = 5'd16 >> r_k;
   assign w_en      = r_shamt[3'd4 - r_k];
   assign w_shifted = r_op ? 32'($signed(r_work) >>> w_amt) : r_work << w_amt;
   assign w_next    = w_en ? w_shifted : r_work;
   always_ff @(posedge i_clock) begin
      if (!i_reset_n) begin
         r_state  <= IDLE;
         r_k      <= 3'd0;
         r_work   <= 32'd0;
         r_shamt  <= 5'd0;
         r_op     <= 1'b0;
         r_result <= 32'd0;
         r_valid  <= 1'b0;
         r_ready  <= 1'b1;
         r_busy   <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         case (r_state)
            IDLE, DONE: begin
               if (w_accept) begin
                  r_work  <= i_data_in;
                  r_shamt <= i_shamt;
                  r_op    <= i_op_sra;
                  r_k     <= 3'd0;
                  r_state <= SHIFT;
                  r_ready <= 1'b0;
                  r_busy  <= 1'b1;
               end else begin
                  r_state <= IDLE;
                  r_ready <= 1'b1;
                  r_busy  <= 1'b0;
               end
            end
            SHIFT: begin
               r_work <= w_next;
               if (r_k == 3'd4) begin
                  r_k      <= 3'd0;
                  r_result <= w_next;
                  r_valid  <= 1'b1;
                  r_state  <= DONE;
                  r_ready  <= 1'b1;
                  r_busy   <= 1'b0;
               end else begin
                  r_k <= r_k + 3'd1;
               end
            end
            default: begin
               r_state <= IDLE;
               r_k     <= 3'd0;
               r_ready <= 1'b1;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end
   assign o_ready        = r_ready;
   assign o_busy         = r_busy;
   assign o_result       = r_result;
   assign o_result_valid = r_valid;
endmodule
